// File: rtl/seg_mmu.sv
// Segmented MMU: NCH requesters share one memory port through round-robin arbitration.
// Each channel relocates its logical address by base[i] and faults on addr > limit[i].
module seg_mmu #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    rd,
    input  logic [NCH-1:0]    wd,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [DW-1:0]     rdata,
    output logic [NCH-1:0]    wait_o,
    output logic [NCH-1:0]    segv,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic              cfg_sel,
    input  logic [AW-1:0]     cfg_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic            fault_q, fault_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   base_q [NCH];
    logic [AW-1:0]   base_d [NCH];
    logic [AW-1:0]   limit_q [NCH];
    logic [AW-1:0]   limit_d [NCH];

    logic [NCH-1:0]  pending;
    logic [AW-1:0]   addr_a [NCH];
    logic [DW-1:0]   wdata_a [NCH];
    logic            found_hi, found_lo, found;
    logic [CW-1:0]   pick_hi, pick_lo, pick;
    logic [AW-1:0]   sel_addr;
    logic            sel_fault;

    always_comb begin
        pending = rd | wd;
        for (int i = 0; i < NCH; i++) begin
            addr_a[i]  = addr[i*AW +: AW];
            wdata_a[i] = wdata[i*DW +: DW];
        end
    end

    // Round-robin: the lowest pending channel at or above rr wins; otherwise wrap to the lowest below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (CW'(i) >= rr_q) begin
                    found_hi = 1'b1;
                    pick_hi  = CW'(i);
                end else begin
                    found_lo = 1'b1;
                    pick_lo  = CW'(i);
                end
            end
        end
        found     = found_hi | found_lo;
        pick      = found_hi ? pick_hi : pick_lo;
        sel_addr  = addr_a[pick];
        sel_fault = sel_addr > limit_q[pick];
    end

    // NOTE: every *_d gets its *_q as default first, so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        fault_d     = fault_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        base_d      = base_q;
        limit_d     = limit_q;

        case (state_q)
            IDLE: begin
                rdata_d = '0;
                if (found) begin
                    grant_d     = pick;
                    mem_we_d    = wd[pick];
                    mem_addr_d  = base_q[pick] + sel_addr;
                    mem_wdata_d = wdata_a[pick];
                    fault_d     = sel_fault;
                    rr_d        = (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
                    if (sel_fault) begin
                        state_d = DONE;
                    end else begin
                        state_d   = ISSUE;
                        mem_req_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Translation for the current grant was taken from *_q above, so a same-cycle write cannot affect it.
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == CW'(i)) begin
                if (cfg_sel) limit_d[i] = cfg_wdata;
                else         base_d[i]  = cfg_wdata;
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            fault_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            // NOTE: the segment registers are reset too, since base 0 / limit all-ones is the defined start-up map.
            for (int i = 0; i < NCH; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '1;
            end
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            fault_q     <= fault_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            base_q      <= base_d;
            limit_q     <= limit_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wait_o[i] = pending[i] & ~(state_q == DONE && grant_q == CW'(i));
            segv[i]   = (state_q == DONE) && (grant_q == CW'(i)) && fault_q;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_seg_mmu.sv
// Bench for seg_mmu (NCH=4): transaction-level model checked every cycle plus directed literal checks.
module tb_seg_mmu;
    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    rd, wd;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [DW-1:0]     rdata;
    logic [NCH-1:0]    wait_o, segv;
    logic              cfg_we;
    logic [CW-1:0]     cfg_ch;
    logic              cfg_sel;
    logic [AW-1:0]     cfg_wdata;
    logic              mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;

    always #5 clk = ~clk;

    seg_mmu #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .rd(rd), .wd(wd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .wait_o(wait_o), .segv(segv),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    logic [AW-1:0] m_base [NCH];
    logic [AW-1:0] m_limit [NCH];
    bit            m_busy, m_done, m_we, m_fault;
    int            m_ch, m_rr;
    logic [AW-1:0] m_phys;
    logic [DW-1:0] m_wdata, m_resp;
    int            m_next;

    function automatic int pick_ch(input int rr, input logic [NCH-1:0] p);
        for (int k = 0; k < NCH; k++) begin
            if (p[(rr + k) % NCH]) return (rr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] ch_addr(input int c);
        return addr[c*AW +: AW];
    endfunction

    assign m_next = pick_ch(m_rr, rd | wd);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rr   <= 0;
            m_resp <= '0;
            for (int i = 0; i < NCH; i++) begin
                m_base[i]  <= '0;
                m_limit[i] <= '1;
            end
        end else begin
            if (m_done) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end else if (m_busy) begin
                if (mem_ack) begin
                    m_done <= 1'b1;
                    m_resp <= m_we ? '0 : mem_rdata;
                end
            end else if (m_next >= 0) begin
                m_ch    <= m_next;
                m_we    <= wd[m_next];
                m_phys  <= m_base[m_next] + ch_addr(m_next);
                m_fault <= ch_addr(m_next) > m_limit[m_next];
                m_done  <= ch_addr(m_next) > m_limit[m_next];
                m_wdata <= wdata[m_next*DW +: DW];
                m_rr    <= (m_next + 1) % NCH;
                m_busy  <= 1'b1;
                m_resp  <= '0;
            end
            if (cfg_we) begin
                if (cfg_sel) m_limit[cfg_ch] <= cfg_wdata;
                else         m_base[cfg_ch]  <= cfg_wdata;
            end
        end
    end

    int done_q[$];

    task automatic compare_cycle();
        logic [NCH-1:0] ew, es;
        bit exp_req;
        exp_req = m_busy && !m_done;
        check("mem_req", mem_req, exp_req);
        if (exp_req) begin
            check("mem_addr", mem_addr, m_phys);
            check("mem_we", mem_we, m_we);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        for (int i = 0; i < NCH; i++) begin
            ew[i] = (rd[i] | wd[i]) && !(m_done && m_ch == i);
            es[i] = m_done && m_ch == i && m_fault;
        end
        check("wait_o", wait_o, ew);
        check("segv", segv, es);
        if (m_done) check("rdata", rdata, m_resp);
        for (int i = 0; i < NCH; i++) begin
            if ((rd[i] | wd[i]) && !wait_o[i]) done_q.push_back(i);
        end
    endtask

    always @(negedge clk) if (rst_n) compare_cycle();

    // ---------------- stimulus helpers ----------------
    task automatic cfg_write(input int ch, input bit sel, input logic [AW-1:0] val);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = sel; cfg_wdata = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_req(input int ch, input bit r, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int ack_delay,
                           output int lat, output int req_cyc, output logic [AW-1:0] c_addr,
                           output logic c_we, output logic [DW-1:0] c_wdata,
                           output logic [NCH-1:0] c_segv, output logic [DW-1:0] c_rdata);
        rd[ch] = r; wd[ch] = w;
        addr[ch*AW +: AW]  = a;
        wdata[ch*DW +: DW] = d;
        mem_ack = 1'b0;
        lat = -1; req_cyc = 0; c_addr = 'x; c_we = 1'bx; c_wdata = 'x; c_segv = 'x; c_rdata = 'x;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                if (req_cyc == 0) begin
                    c_addr = mem_addr; c_we = mem_we; c_wdata = mem_wdata;
                end
                req_cyc++;
                mem_ack = (req_cyc > ack_delay);
            end
            if (!wait_o[ch]) begin
                lat = cyc; c_segv = segv; c_rdata = rdata;
                break;
            end
        end
        @(posedge clk); #1;
        rd[ch] = 1'b0; wd[ch] = 1'b0; mem_ack = 1'b0;
    endtask

    int               lat, req_cyc;
    logic [AW-1:0]    c_addr;
    logic             c_we;
    logic [DW-1:0]    c_wdata, c_rdata;
    logic [NCH-1:0]   c_segv;
    int               exp_order[5] = '{0, 1, 2, 3, 0};
    bit               seen;

    initial begin
        rst_n = 1'b0; rd = '0; wd = '0; addr = '0; wdata = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #3 rd = 4'b0101;
        #4;
        check("rst_wait_o", wait_o, 4'b0101);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_segv", segv, 4'b0000);
        rd = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Single relocated read on ch0
        cfg_write(0, 1'b0, 32'h1000);
        mem_rdata = 32'hDEADBEEF;
        run_req(0, 1, 0, 32'h20, 32'h0, 0, lat, req_cyc, c_addr, c_we, c_wdata, c_segv, c_rdata);
        check("t1_lat", lat, 2);
        check("t1_mem_addr", c_addr, 32'h1020);
        check("t1_mem_we", c_we, 1'b0);
        check("t1_req_cycles", req_cyc, 1);
        check("t1_rdata", c_rdata, 32'hDEADBEEF);
        check("t1_segv", c_segv, 4'b0000);

        // Write with late ack on ch1
        run_req(1, 0, 1, 32'h8, 32'h55, 3, lat, req_cyc, c_addr, c_we, c_wdata, c_segv, c_rdata);
        check("t2_lat", lat, 5);
        check("t2_req_cycles", req_cyc, 4);
        check("t2_mem_we", c_we, 1'b1);
        check("t2_mem_wdata", c_wdata, 32'h55);
        check("t2_mem_addr", c_addr, 32'h8);
        check("t2_rdata", c_rdata, 32'h0);

        // Limit fault, then the last valid offset
        cfg_write(1, 1'b1, 32'hFF);
        run_req(1, 1, 0, 32'h100, 32'h0, 0, lat, req_cyc, c_addr, c_we, c_wdata, c_segv, c_rdata);
        check("t3_fault_lat", lat, 1);
        check("t3_fault_no_req", req_cyc, 0);
        check("t3_fault_segv", c_segv, 4'b0010);
        check("t3_fault_rdata", c_rdata, 32'h0);
        run_req(1, 1, 0, 32'hFF, 32'h0, 0, lat, req_cyc, c_addr, c_we, c_wdata, c_segv, c_rdata);
        check("t3_edge_lat", lat, 2);
        check("t3_edge_addr", c_addr, 32'hFF);
        check("t3_edge_segv", c_segv, 4'b0000);

        // Address wrap, rd+wd together is a write
        cfg_write(2, 1'b0, 32'hFFFF_FFF0);
        run_req(2, 1, 1, 32'h20, 32'hAB, 0, lat, req_cyc, c_addr, c_we, c_wdata, c_segv, c_rdata);
        check("t4_lat", lat, 2);
        check("t4_mem_addr", c_addr, 32'h10);
        check("t4_mem_we", c_we, 1'b1);
        check("t4_segv", c_segv, 4'b0000);
        check("t4_rdata", c_rdata, 32'h0);

        // Contention: all four channels read continuously from a fresh reset
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) addr[i*AW +: AW] = AW'(i * 16);
        mem_rdata = 32'h1234_5678;
        mem_ack = 1'b1;
        done_q.delete();
        rd = 4'hF;
        for (int cyc = 0; cyc < 60 && done_q.size() < 5; cyc++) @(posedge clk);
        #1 rd = '0;
        check("t5_grants", done_q.size() >= 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k < done_q.size()) check($sformatf("t5_grant%0d", k), done_q[k], exp_order[k]);
        end

        // Async reset while ch0 is in ISSUE
        mem_ack = 1'b0;
        addr[0 +: AW] = 32'h40;
        addr[AW +: AW] = 32'h50;
        rd[0] = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            seen = mem_req;
        end
        check("t6_req_seen", seen, 1'b1);
        check("t6_mem_addr", mem_addr, 32'h40);
        #1 rst_n = 1'b0;
        #1;
        check("t6_req_async_drop", mem_req, 1'b0);
        rd[1] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        done_q.delete();
        for (int cyc = 0; cyc < 20 && done_q.size() < 2; cyc++) @(posedge clk);
        #1 rd = '0; mem_ack = 1'b0;
        check("t6_completions", done_q.size() >= 2, 1'b1);
        if (done_q.size() >= 2) begin
            check("t6_first_grant", done_q[0], 0);
            check("t6_second_grant", done_q[1], 1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
